// File: rtl/guess_sender.sv
// Player-side guess initiator for the hangman core: buffers host guesses, strobes them out, scores the mask.
// Optional duplicate-letter filter enabled by defining GUESS_SENDER_DUP_FILTER_EN.
module guess_sender #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned RESP_CYCLES  = 8,
  parameter int unsigned START_CYCLES = 3,
  parameter int unsigned MAX_MISSES   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       guess_valid,
  input  logic [4:0] guess_letter,
  output logic       guess_ready,
  output logic [5:0] chip_input,
  input  logic [6:0] chip_output,
  output logic       result_valid,
  output logic       result_hit,
  output logic       result_dup,
  output logic [4:0] mask,
  output logic [3:0] misses,
  output logic       game_won,
  output logic       game_lost,
  output logic       busy
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_MAX = (RESP_CYCLES > START_CYCLES) ? RESP_CYCLES : START_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [3:0]  MAX_M   = 4'(MAX_MISSES);

  typedef enum logic [3:0] {
    S_IDLE, S_PREP, S_LAUNCH, S_SETTLE, S_READY, S_SEND, S_WAIT, S_EVAL, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         cur_q, cur_d;
  logic [5:0]         chip_q, chip_d;
  logic [4:0]         mask_q;
  logic [3:0]         misses_q;
  logic               won_q, lost_q, ended_q;
  logic               res_valid_q, res_hit_q;
  logic               restart, pop, push, flush, dup_skip, is_dup, sample, hit;
  logic [4:0]         new_mask, head;

  logic [4:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [PTR_W:0]     count_q;
  logic               unused_chip_hi;

  assign unused_chip_hi = ^chip_output[6:5];
  assign head     = fifo_mem[rd_q];
  assign new_mask = chip_output[4:0];
  assign hit      = |(new_mask & ~mask_q);

  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    pop      = 1'b0;
    dup_skip = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = ended_q ? S_PREP : S_LAUNCH;
      S_PREP:   if (cnt_q == CNT_W'(1)) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == CNT_W'(START_CYCLES - 1)) state_d = S_READY;
      S_READY: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (is_dup) dup_skip = 1'b1;
          else        state_d  = S_SEND;
        end
      end
      S_SEND:   state_d = S_WAIT;
      S_WAIT:   if (cnt_q == CNT_W'(RESP_CYCLES - 1)) state_d = S_EVAL;
      S_EVAL:   state_d = (mask_q == '1 || misses_q >= MAX_M) ? S_DONE : S_READY;
      S_DONE:   ;
      default:  state_d = S_IDLE;
    endcase
    // start anywhere but IDLE aborts; a strobe already on chip_input has its full cycle
    if (start && state_q != S_IDLE) begin
      state_d  = S_PREP;
      restart  = 1'b1;
      pop      = 1'b0;
      dup_skip = 1'b0;
    end
  end

  always_comb begin
    flush  = (start && state_q != S_IDLE) || state_q == S_LAUNCH || state_q == S_DONE;
    push   = guess_valid && guess_ready && !flush;
    sample = (state_q == S_WAIT) && (state_d == S_EVAL);
    cnt_d  = (state_d != state_q || restart) ? '0 : cnt_q + 1'b1;
    cur_d  = pop ? head : cur_q;
    chip_d = '0;
    case (state_d)
      S_PREP:   if (cnt_d == '0) chip_d = 6'b100000;
      S_LAUNCH: chip_d = '1;
      S_SEND:   chip_d = {1'b1, cur_d};
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      chip_q      <= '0;
      mask_q      <= '0;
      misses_q    <= '0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
      ended_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      chip_q      <= chip_d;
      res_valid_q <= sample || dup_skip;
      res_hit_q   <= sample && hit;
      if (sample) begin
        mask_q <= new_mask;
        if (!hit && misses_q != 4'hf) misses_q <= misses_q + 4'd1;
      end
      if (state_q == S_LAUNCH) begin
        mask_q   <= '0;
        misses_q <= '0;
      end
      if (start || state_q == S_LAUNCH) begin
        won_q  <= 1'b0;
        lost_q <= 1'b0;
      end
      if (state_q == S_EVAL && state_d == S_DONE) begin
        ended_q <= 1'b1;
        if (mask_q == '1) won_q  <= 1'b1;
        else              lost_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_q] <= guess_letter;
  end

`ifdef GUESS_SENDER_DUP_FILTER_EN
  logic [31:0] guessed_q;
  logic        dup_q;

  assign is_dup     = guessed_q[head];
  assign result_dup = dup_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      guessed_q <= '0;
      dup_q     <= 1'b0;
    end else begin
      dup_q <= dup_skip;
      if (state_q == S_LAUNCH)   guessed_q       <= '0;
      else if (pop && !dup_skip) guessed_q[head] <= 1'b1;
    end
  end
`else
  assign is_dup     = 1'b0;
  assign result_dup = 1'b0;
`endif

  // FIFO full is the count MSB because FIFO_DEPTH is a power of two
  assign guess_ready  = !count_q[PTR_W] &&
                        (state_q == S_SETTLE || state_q == S_READY || state_q == S_SEND ||
                         state_q == S_WAIT   || state_q == S_EVAL);
  assign busy         = !(state_q == S_IDLE || state_q == S_READY) || (count_q != '0);
  assign chip_input   = chip_q;
  assign result_valid = res_valid_q;
  assign result_hit   = res_hit_q;
  assign mask         = mask_q;
  assign misses       = misses_q;
  assign game_won     = won_q;
  assign game_lost    = lost_q;

endmodule

// File: tb/tb_guess_sender.sv
// Directed bench for guess_sender with a behavioural hangman core (word "notre") and a result scoreboard.
module tb_guess_sender;
  localparam int unsigned RESP   = 8;
  localparam int unsigned STARTC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       guess_valid = 1'b0;
  logic [4:0] guess_letter = '0;
  logic       guess_ready;
  logic [5:0] chip_input;
  logic [6:0] chip_output;
  logic       result_valid, result_hit, result_dup;
  logic [4:0] mask;
  logic [3:0] misses;
  logic       game_won, game_lost, busy;

  always #5 clk = ~clk;

  guess_sender #(
    .FIFO_DEPTH(4), .RESP_CYCLES(RESP), .START_CYCLES(STARTC), .MAX_MISSES(7)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .guess_valid(guess_valid),
    .guess_letter(guess_letter), .guess_ready(guess_ready), .chip_input(chip_input),
    .chip_output(chip_output), .result_valid(result_valid), .result_hit(result_hit),
    .result_dup(result_dup), .mask(mask), .misses(misses), .game_won(game_won),
    .game_lost(game_lost), .busy(busy)
  );

  // Core model: mask bit 4 is the first letter of "notre" (a=0)
  function automatic logic [4:0] match(input logic [4:0] l);
    logic [4:0] m;
    m = '0;
    if (l == 5'd13) m[4] = 1'b1;
    if (l == 5'd14) m[3] = 1'b1;
    if (l == 5'd19) m[2] = 1'b1;
    if (l == 5'd17) m[1] = 1'b1;
    if (l == 5'd4)  m[0] = 1'b1;
    return m;
  endfunction

  logic [4:0] core_reveal = '0;
  always @(posedge clk) begin
    if (chip_input == 6'h3f)  core_reveal <= '0;
    else if (chip_input[5])   core_reveal <= core_reveal | match(chip_input[4:0]);
  end
  assign chip_output = {2'b11, core_reveal};

  logic [5:0] obs_strb[$];
  always @(negedge clk) if (chip_input != '0) obs_strb.push_back(chip_input);

  typedef struct packed {
    logic       hit;
    logic       dup;
    logic [4:0] mask;
    logic [3:0] misses;
  } res_t;

  res_t       sb[$];
  logic [5:0] exp_strb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_res = 0;
  int         tgt   = 0;
  int         cyc;
  logic [4:0] exp_reveal = '0;
  logic [3:0] exp_misses = '0;
  logic [31:0] seen = '0;
  logic [4:0] lose_l [7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take_result();
    res_t e;
    n_res++;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_bad++;
      $error("FAIL unexpected_result: observed result_valid with empty scoreboard, expected none");
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("res_hit",    result_hit, e.hit);
    check("res_dup",    result_dup, e.dup);
    check("res_mask",   mask,       e.mask);
    check("res_misses", misses,     e.misses);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (result_valid) take_result();
  endtask

  task automatic wait_results(input int target, output int cycles);
    cycles = 0;
    while (n_res < target && cycles < 80) begin
      step();
      cycles++;
    end
    check("result_timeout", (n_res >= target), 1);
  endtask

  task automatic model(input logic [4:0] l);
    res_t e;
    logic [4:0] nm;
`ifdef GUESS_SENDER_DUP_FILTER_EN
    if (seen[l]) begin
      e = '{hit: 1'b0, dup: 1'b1, mask: exp_reveal, misses: exp_misses};
      sb.push_back(e);
      return;
    end
    seen[l] = 1'b1;
`endif
    exp_strb.push_back({1'b1, l});
    nm    = exp_reveal | match(l);
    e.hit = |(nm & ~exp_reveal);
    e.dup = 1'b0;
    exp_reveal = nm;
    if (!e.hit && exp_misses != 4'hf) exp_misses = exp_misses + 4'd1;
    e.mask   = nm;
    e.misses = exp_misses;
    sb.push_back(e);
  endtask

  task automatic push(input logic [4:0] l);
    int w;
    w = 0;
    guess_valid  = 1'b1;
    guess_letter = l;
    while (!guess_ready && w < 80) begin
      step();
      w++;
    end
    check("push_timeout", guess_ready, 1);
    step();
    guess_valid = 1'b0;
    model(l);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic new_game_model(input bit from_prep);
    if (from_prep) exp_strb.push_back(6'h20);
    exp_strb.push_back(6'h3f);
    exp_reveal = '0;
    exp_misses = '0;
    seen       = '0;
  endtask

  task automatic begin_game(input bit from_prep);
    new_game_model(from_prep);
    pulse_start();
    repeat (from_prep ? 6 : 4) step();
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_count"}, obs_strb.size(), exp_strb.size());
    for (int i = 0; i < exp_strb.size(); i++)
      if (i < obs_strb.size()) check(tag, obs_strb[i], exp_strb[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_chip",   chip_input,   0);
    check("rst_mask",   mask,         0);
    check("rst_misses", misses,       0);
    check("rst_rvalid", result_valid, 0);
    check("rst_won",    game_won,     0);
    check("rst_lost",   game_lost,    0);
    check("rst_ready",  guess_ready,  0);
    check("rst_busy",   busy,         0);
    reset = 1'b1;
    step();
    step();

    // new game from IDLE, then the "notre" win path
    new_game_model(1'b0);
    pulse_start();
    check("launch_strobe", chip_input, 6'h3f);
    step();
    check("launch_one_cycle", chip_input, 0);
    repeat (STARTC) step();
    check("ready_after_settle", guess_ready, 1);
    check("ready_not_busy",     busy,        0);

    push(5'd13); tgt++; wait_results(tgt, cyc);
    check("latency", cyc, RESP + 2);
    push(5'd14); tgt++; wait_results(tgt, cyc);
    check("mask_after_o", mask, 5'b11000);
    push(5'd19); tgt++; wait_results(tgt, cyc);
    push(5'd17); tgt++; wait_results(tgt, cyc);
    push(5'd4);  tgt++; wait_results(tgt, cyc);
    step();
    check("won",            game_won,    1);
    check("won_not_lost",   game_lost,   0);
    check("won_ready_low",  guess_ready, 0);
    check_strobes("win_strobes");

    // restart from DONE goes through PREP
    new_game_model(1'b1);
    pulse_start();
    check("prep_strobe", chip_input, 6'h20);
    step();
    check("prep_gap", chip_input, 0);
    step();
    check("relaunch", chip_input, 6'h3f);
    check("won_cleared", game_won, 0);
    repeat (STARTC + 1) step();
    check("new_mask_clear",   mask,   0);
    check("new_misses_clear", misses, 0);

`ifdef GUESS_SENDER_DUP_FILTER_EN
    lose_l = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd7};
`else
    lose_l = '{default: 5'd0};
`endif
    for (int i = 0; i < 7; i++) begin
      push(lose_l[i]);
      tgt++;
      wait_results(tgt, cyc);
    end
    step();
    check("lost",           game_lost,   1);
    check("lost_not_won",   game_won,    0);
    check("lost_misses",    misses,      7);
    check("lost_ready_low", guess_ready, 0);
    check_strobes("lose_strobes");

    // FIFO fills while the first guess waits for its response
    begin_game(1'b1);
    push(5'd13);
    repeat (3) step();
    push(5'd1);
    push(5'd2);
    push(5'd14);
    push(5'd19);
    check("full_ready_low", guess_ready, 0);
    check("full_busy",      busy,        1);
    push(5'd17);
    tgt += 6;
    wait_results(tgt, cyc);
    check("fifo_mask", mask, 5'b11110);
    check_strobes("fifo_order");

    // asynchronous reset in the middle of WAIT
    push(5'd5);
    repeat (4) step();
    check("wait_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_chip",   chip_input,   0);
    check("arst_mask",   mask,         0);
    check("arst_misses", misses,       0);
    check("arst_rvalid", result_valid, 0);
    check("arst_ready",  guess_ready,  0);
    check("arst_busy",   busy,         0);
    check("arst_won",    game_won,     0);
    sb.delete();
    check_strobes("pre_reset");
    @(negedge clk);
    reset = 1'b1;
    step();

    begin_game(1'b0);
`ifdef GUESS_SENDER_DUP_FILTER_EN
    push(5'd14); tgt++; wait_results(tgt, cyc);
    push(5'd14); tgt++; wait_results(tgt, cyc);
    check("dup_misses", misses, 0);
    check_strobes("dup_no_strobe");
`else
    push(5'd14); tgt++; wait_results(tgt, cyc);
`endif
    // abort from READY
    new_game_model(1'b1);
    pulse_start();
    check("abort_prep", chip_input, 6'h20);
    step();
    check("abort_gap", chip_input, 0);
    step();
    check("abort_launch", chip_input, 6'h3f);
    repeat (STARTC + 1) step();
    check_strobes("abort_strobes");
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
